// File: rtl/jump_move_if.sv
// Movement controller bundle: per-tick key/collision inputs and
// registered movement outputs.
interface jump_move_if #(
  parameter int TICK_W = 11
);
  logic              frame_tick;
  logic [3:0]        arrow;
  logic [3:0]        collision;
  logic              enable_jump;
  logic [3:0]        move_dir;
  logic [1:0]        jump_state;
  logic              airborne;
  logic [TICK_W-1:0] jump_cnt;

  modport master (
    output frame_tick, arrow, collision, enable_jump,
    input  move_dir, jump_state, airborne, jump_cnt
  );

  modport slave (
    input  frame_tick, arrow, collision, enable_jump,
    output move_dir, jump_state, airborne, jump_cnt
  );
endinterface

// File: rtl/jump_move_ctrl.sv
// Tick-driven jump FSM with apex hang, coyote time and head-bump abort.
// Optional DOUBLE_JUMP_EN macro adds one air jump per airborne period.
module jump_move_ctrl #(
  parameter int TICK_W         = 11,
  parameter int JUMP_TICKS_MAX = 30,
  parameter int JUMP_TICKS_MIN = 8,
  parameter int APEX_TICKS     = 3,
  parameter int COYOTE_TICKS   = 4
) (
  input logic        clk,
  input logic        rst_n,
  jump_move_if.slave bus
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    APEX   = 2'd2,
    FALL   = 2'd3
  } st_t;

  localparam logic [TICK_W-1:0] MAX_M1 =
    TICK_W'(JUMP_TICKS_MAX - 1);
  localparam logic [TICK_W-1:0] MIN_M1 =
    TICK_W'(JUMP_TICKS_MIN - 1);
  localparam logic [TICK_W-1:0] APEX_M1 =
    TICK_W'((APEX_TICKS > 0) ? APEX_TICKS - 1 : 0);
  localparam logic [TICK_W-1:0] COY =
    TICK_W'(COYOTE_TICKS);
  localparam logic [TICK_W-1:0] SAT = '1;

  st_t               st_q, st_d;
  logic [TICK_W-1:0] cnt_q, cnt_d;
  // apex hang timer in APEX, coyote countdown in FALL
  logic [TICK_W-1:0] tmr_q, tmr_d;
  logic              prev_q;
  logic [3:0]        dir_q, dir_d;
  logic              jedge;
  logic              rise_end;
`ifdef DOUBLE_JUMP_EN
  logic              air_q, air_d;
`endif

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    tmr_d = tmr_q;
`ifdef DOUBLE_JUMP_EN
    air_d = air_q;
`endif
    jedge = bus.arrow[3] & ~prev_q & bus.enable_jump;
    rise_end = (cnt_q == MAX_M1) |
               (~bus.arrow[3] & (cnt_q >= MIN_M1));
    unique case (st_q)
      GROUND: begin
`ifdef DOUBLE_JUMP_EN
        air_d = 1'b0;
`endif
        if (jedge & ~bus.collision[3]) begin
          st_d  = RISE;
          cnt_d = '0;
        end else if (~bus.collision[2]) begin
          st_d  = FALL;
          tmr_d = COY;
        end
      end
      RISE: begin
        if (bus.collision[3]) begin
          st_d  = FALL;
          tmr_d = '0;
`ifdef DOUBLE_JUMP_EN
        end else if (jedge & ~air_q) begin
          st_d  = RISE;
          cnt_d = '0;
          air_d = 1'b1;
`endif
        end else if (rise_end) begin
          st_d  = (APEX_TICKS == 0) ? FALL : APEX;
          tmr_d = '0;
        end else if (cnt_q != SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      APEX: begin
        if (bus.collision[2]) begin
          st_d = GROUND;
`ifdef DOUBLE_JUMP_EN
        end else if (jedge & ~air_q & ~bus.collision[3]) begin
          st_d  = RISE;
          cnt_d = '0;
          air_d = 1'b1;
`endif
        end else if (tmr_q >= APEX_M1) begin
          st_d  = FALL;
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      FALL: begin
        if (bus.collision[2]) begin
          st_d = GROUND;
        end else if (jedge & (tmr_q != '0) &
                     ~bus.collision[3]) begin
          st_d  = RISE;
          cnt_d = '0;
`ifdef DOUBLE_JUMP_EN
        end else if (jedge & ~air_q & ~bus.collision[3]) begin
          st_d  = RISE;
          cnt_d = '0;
          air_d = 1'b1;
`endif
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: st_d = GROUND;
    endcase
    dir_d = {
      st_d == RISE,
      st_d == FALL,
      bus.arrow[1] & ~bus.arrow[0] & ~bus.collision[1],
      bus.arrow[0] & ~bus.arrow[1] & ~bus.collision[0]
    };
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= GROUND;
      cnt_q  <= '0;
      tmr_q  <= '0;
      prev_q <= 1'b0;
      dir_q  <= '0;
`ifdef DOUBLE_JUMP_EN
      air_q  <= 1'b0;
`endif
    end else if (bus.frame_tick) begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      tmr_q  <= tmr_d;
      prev_q <= bus.arrow[3];
      dir_q  <= dir_d;
`ifdef DOUBLE_JUMP_EN
      air_q  <= air_d;
`endif
    end
  end

  assign bus.move_dir   = dir_q;
  assign bus.jump_state = st_q;
  assign bus.airborne   = (st_q != GROUND);
  assign bus.jump_cnt   = cnt_q;

endmodule

// File: tb/tb_jump_move_ctrl.sv
// Directed and randomized bench for jump_move_ctrl against a
// tick-level behavioural model.
module tb_jump_move_ctrl;

  localparam int W    = 11;
  localparam int JMAX = 30;
  localparam int JMIN = 8;
  localparam int APX  = 3;
  localparam int COY  = 4;
`ifdef DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jump_move_if #(.TICK_W(W)) bus ();

  jump_move_ctrl #(
    .TICK_W(W),
    .JUMP_TICKS_MAX(JMAX),
    .JUMP_TICKS_MIN(JMIN),
    .APEX_TICKS(APX),
    .COYOTE_TICKS(COY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: phase 0 ground, 1 rise, 2 apex, 3 fall
  int       m_state, m_rise, m_coy, m_hang;
  bit       m_prev, m_air;
  bit [3:0] m_dir;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_rise = 0; m_coy = 0; m_hang = 0;
    m_prev = 0; m_air = 0; m_dir = '0;
  endtask

  task automatic model_step(input logic [3:0] a,
                            input logic [3:0] c,
                            input logic e);
    bit jmp;
    bit air_jmp;
    int nxt;
    jmp = a[3] && !m_prev && e;
    air_jmp = DJ && jmp && !m_air && !c[3];
    m_prev = a[3];
    nxt = m_state;
    case (m_state)
      0: begin
        if (jmp && !c[3]) begin nxt = 1; m_rise = 0; end
        else if (!c[2]) begin nxt = 3; m_coy = COY; end
      end
      1: begin
        if (c[3]) begin nxt = 3; m_coy = 0; end
        else if (air_jmp) begin
          nxt = 1; m_rise = 0; m_air = 1;
        end else if (m_rise == JMAX - 1 ||
                     (!a[3] && m_rise >= JMIN - 1)) begin
          if (APX == 0) begin nxt = 3; m_coy = 0; end
          else begin nxt = 2; m_hang = APX - 1; end
        end else if (m_rise < (1 << W) - 1) m_rise++;
      end
      2: begin
        if (c[2]) nxt = 0;
        else if (air_jmp) begin
          nxt = 1; m_rise = 0; m_air = 1;
        end else if (m_hang == 0) begin nxt = 3; m_coy = 0; end
        else m_hang--;
      end
      default: begin
        if (c[2]) nxt = 0;
        else if (jmp && m_coy > 0 && !c[3]) begin
          nxt = 1; m_rise = 0;
        end else if (air_jmp) begin
          nxt = 1; m_rise = 0; m_air = 1;
        end else if (m_coy > 0) m_coy--;
      end
    endcase
    if (nxt == 0) m_air = 0;
    m_state = nxt;
    m_dir = {nxt == 1, nxt == 3,
             a[1] && !a[0] && !c[1],
             a[0] && !a[1] && !c[0]};
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_dir"}, 32'(bus.move_dir), 32'(m_dir));
    chk({tag, "_st"}, 32'(bus.jump_state), 32'(m_state));
    chk({tag, "_air"}, 32'(bus.airborne), 32'(m_state != 0));
    chk({tag, "_cnt"}, 32'(bus.jump_cnt), 32'(m_rise));
  endtask

  task automatic tick(input logic [3:0] a,
                      input logic [3:0] c,
                      input logic e,
                      input int idle);
    @(negedge clk);
    bus.arrow = a;
    bus.collision = c;
    bus.enable_jump = e;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    model_step(a, c, e);
    check_all("tick");
    for (int k = 0; k < idle; k++) begin
      bus.arrow = 4'($urandom);
      bus.collision = 4'($urandom);
      bus.enable_jump = 1'($urandom);
      @(negedge clk);
      check_all("hold");
    end
  endtask

  int ups, zeros, falls, first_non_up;
  logic [3:0] ra, rc;

  initial begin
    bus.frame_tick = 1'b0;
    bus.arrow = '0;
    bus.collision = '0;
    bus.enable_jump = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // full jump with up held
    tick(4'b0000, 4'b0100, 1'b1, 1);
    tick(4'b1000, 4'b0100, 1'b1, 0);
    ups = bus.move_dir[3];
    zeros = 0; falls = 0;
    for (int i = 0; i < 40; i++) begin
      tick(4'b1000, 4'b0000, 1'b1, 0);
      if (bus.move_dir[3]) ups++;
      else if (bus.move_dir[2]) falls++;
      else zeros++;
    end
    chk("full_up", 32'(ups), 32'd30);
    chk("full_apex", 32'(zeros), 32'd3);
    chk("full_fall", 32'(falls), 32'd8);
    tick(4'b1000, 4'b0100, 1'b1, 0);
    chk("full_land", 32'(bus.jump_state), 32'd0);
    tick(4'b0000, 4'b0100, 1'b1, 0);

    // short hop: three ticks of up then release
    tick(4'b1000, 4'b0100, 1'b1, 0);
    ups = 1;
    first_non_up = -1;
    tick(4'b1000, 4'b0000, 1'b1, 0);
    ups++;
    tick(4'b1000, 4'b0000, 1'b1, 0);
    ups++;
    for (int i = 0; i < 15; i++) begin
      tick(4'b0000, 4'b0000, 1'b1, 0);
      if (bus.move_dir[3]) ups++;
      else if (first_non_up < 0) first_non_up = bus.jump_state;
    end
    chk("hop_up", 32'(ups), 32'd8);
    chk("hop_apex", 32'(first_non_up), 32'd2);
    tick(4'b0000, 4'b0100, 1'b1, 0);

    // head bump on the fifth rise tick
    tick(4'b1000, 4'b0100, 1'b1, 0);
    repeat (4) tick(4'b1000, 4'b0000, 1'b1, 0);
    tick(4'b1000, 4'b1000, 1'b1, 0);
    chk("bump_st", 32'(bus.jump_state), 32'd3);
    chk("bump_down", 32'(bus.move_dir[3:2]), 32'b01);
    tick(4'b1000, 4'b0000, 1'b1, 0);
    chk("bump_noapex", 32'(bus.jump_state), 32'd3);
    tick(4'b0000, 4'b0100, 1'b1, 0);

    // coyote accepted on fall tick 3
    tick(4'b0000, 4'b0000, 1'b1, 0);
    repeat (2) tick(4'b0000, 4'b0000, 1'b1, 0);
    tick(4'b1000, 4'b0000, 1'b1, 0);
    chk("coy_ok", 32'(bus.jump_state), 32'd1);
    tick(4'b1000, 4'b1000, 1'b1, 0);
    tick(4'b0000, 4'b0100, 1'b1, 0);
    // coyote expired on fall tick 5
    tick(4'b0000, 4'b0000, 1'b1, 0);
    repeat (4) tick(4'b0000, 4'b0000, 1'b1, 0);
    tick(4'b1000, 4'b0000, 1'b1, 0);
    chk("coy_late", 32'(bus.jump_state), 32'd3);
    tick(4'b0000, 4'b0100, 1'b1, 0);

    // horizontal resolution
    tick(4'b0011, 4'b0100, 1'b1, 0);
    chk("h_both", 32'(bus.move_dir[1:0]), 32'b00);
    tick(4'b0010, 4'b0110, 1'b1, 0);
    chk("h_block", 32'(bus.move_dir[1:0]), 32'b00);
    tick(4'b0110, 4'b0100, 1'b1, 0);
    chk("h_left", 32'(bus.move_dir), 32'b0010);

`ifdef DOUBLE_JUMP_EN
    tick(4'b1000, 4'b0100, 1'b1, 0);
    repeat (20) tick(4'b0000, 4'b0000, 1'b1, 0);
    tick(4'b1000, 4'b0000, 1'b1, 0);
    chk("dj_second", 32'(bus.jump_state), 32'd1);
    repeat (20) tick(4'b0000, 4'b0000, 1'b1, 0);
    tick(4'b1000, 4'b0000, 1'b1, 0);
    chk("dj_third", 32'(bus.jump_state), 32'd3);
    tick(4'b0000, 4'b0100, 1'b1, 0);
`endif

    // reset while rising with jump_cnt at 12
    tick(4'b0000, 4'b0100, 1'b1, 0);
    tick(4'b1000, 4'b0100, 1'b1, 0);
    repeat (12) tick(4'b1000, 4'b0000, 1'b1, 0);
    chk("pre_rst_cnt", 32'(bus.jump_cnt), 32'd12);
    @(negedge clk);
    rst_n = 1'b0;
    bus.frame_tick = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    check_all("midrst");
    bus.frame_tick = 1'b0;
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      ra = 4'($urandom);
      rc = 4'($urandom) & 4'($urandom);
      rc[2] = ($urandom_range(0, 3) == 0);
      tick(ra, rc, ($urandom_range(0, 7) != 0),
           int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
